// File: rtl/alb_pkg.sv
// Shared opcode and FSM state encodings for the ALB scheduler slice.
// Pure definitions, no logic; latency and backpressure live in the users.
// Opcodes follow the legacy two-bit ALB function field.
package alb_pkg;

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_ADD  = 2'b01,
        OP_ANDN = 2'b10,
        OP_SUB  = 2'b11
    } alb_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } alb_state_e;

endpackage

// File: rtl/alb_core.sv
// Combinational ALB: OR, ADD, ANDN, SUB with carry-out and signed overflow.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the scheduler registers the outputs.
module alb_core
    import alb_pkg::*;
#(
    parameter int DATA_WIDTH = 11
) (
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  ci,
    output logic [DATA_WIDTH-1:0] y,
    output logic                  co,
    output logic                  ovf
);

    logic [DATA_WIDTH-1:0] a_eff;
    logic [DATA_WIDTH:0]   sum;

    always_comb begin
        // SUB reuses the adder with A inverted, so co=1 means no borrow
        a_eff = (op == OP_SUB) ? ~a : a;
        sum   = {1'b0, b} + {1'b0, a_eff} + {{DATA_WIDTH{1'b0}}, ci};
        y     = '0;
        co    = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_OR:   y = b | a;
            OP_ANDN: y = ~b & a;
            default: begin
                y   = sum[DATA_WIDTH-1:0];
                co  = sum[DATA_WIDTH];
                ovf = (b[DATA_WIDTH-1] == a_eff[DATA_WIDTH-1]) &
                      (sum[DATA_WIDTH-1] != b[DATA_WIDTH-1]);
            end
        endcase
    end

endmodule

// File: rtl/alb_scheduler.sv
// Round-robin shares one ALB between two requesters; result on a valid/ready channel.
// Latency: accept edge, one EXEC cycle, result registered; 1 op per 2 cycles at best.
// Backpressure: rsp_* held while rsp_ready is low; no new grant until the result is taken.
module alb_scheduler
    import alb_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [1:0]            r0_op,
    input  logic [DATA_WIDTH-1:0] r0_a,
    input  logic [DATA_WIDTH-1:0] r0_b,
    input  logic                  r0_ci,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [1:0]            r1_op,
    input  logic [DATA_WIDTH-1:0] r1_a,
    input  logic [DATA_WIDTH-1:0] r1_b,
    input  logic                  r1_ci,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_y,
    output logic                  rsp_co,
    output logic                  rsp_ovf,
    output logic                  rsp_zero,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    alb_state_e            state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  ci_q, ci_d, id_q, id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic                  rsp_co_q, rsp_co_d, rsp_ovf_q, rsp_ovf_d, rsp_zero_q, rsp_zero_d;
    logic [CNT_WIDTH-1:0]  op_count_q, op_count_d;

    logic                  can_accept, grant0, grant1, acc0, acc1, accept;
    logic [DATA_WIDTH-1:0] core_y;
    logic                  core_co, core_ovf;

    alb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .ci  (ci_q),
        .y   (core_y),
        .co  (core_co),
        .ovf (core_ovf)
    );

    always_comb begin
        can_accept = (state_q == IDLE) | ((state_q == DONE) & rsp_ready);
        // On contention the requester that did not win last time goes first
        grant0     = (r0_valid & r1_valid) ? rr_last_q  : r0_valid;
        grant1     = (r0_valid & r1_valid) ? ~rr_last_q : r1_valid;
        // Reset gating keeps ready low while the block is held in reset
        r0_ready   = reset & can_accept & grant0;
        r1_ready   = reset & can_accept & grant1;
        acc0       = r0_valid & r0_ready;
        acc1       = r1_valid & r1_ready;
        accept     = acc0 | acc1;
    end

    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        ci_d        = ci_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_co_d    = rsp_co_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_zero_d  = rsp_zero_q;
        op_count_d  = op_count_q;

        if (accept) begin
            op_d      = acc1 ? r1_op : r0_op;
            a_d       = acc1 ? r1_a  : r0_a;
            b_d       = acc1 ? r1_b  : r0_b;
            ci_d      = acc1 ? r1_ci : r0_ci;
            id_d      = acc1;
            rr_last_d = acc1;
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = EXEC;
            end
            EXEC: begin
                state_d     = DONE;
                rsp_valid_d = 1'b1;
                rsp_y_d     = core_y;
                rsp_co_d    = core_co;
                rsp_ovf_d   = core_ovf;
                rsp_zero_d  = (core_y == '0);
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (op_count_q != '1)
                        op_count_d = op_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d = accept ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            ci_q        <= 1'b0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_co_q    <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ci_q        <= ci_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_co_q    <= rsp_co_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_zero_q  <= rsp_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    // The result owner is the id latched at accept; it stays put through DONE
    assign rsp_id    = rsp_valid_q ? id_q : 1'b0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_co    = rsp_co_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alb_scheduler.sv
// Scoreboard bench for alb_scheduler: directed cases, fairness, back-pressure, reset, random traffic.
module tb_alb_scheduler;
    import alb_pkg::*;

    typedef struct packed {
        logic        id;
        logic [10:0] y;
        logic        co;
        logic        ovf;
        logic        zero;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready, r0_ci, r1_valid, r1_ready, r1_ci;
    logic [1:0]  r0_op, r1_op;
    logic [10:0] r0_a, r0_b, r1_a, r1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_co, rsp_ovf, rsp_zero, busy;
    logic [10:0] rsp_y;
    logic [15:0] op_count;

    int   checks = 0;
    int   errors = 0;
    int   resp_cnt = 0;
    rsp_t exp_q[$];
    logic id_log[$];
    bit   hold = 1'b0;
    bit   stop_rr;
    rsp_t held, cur;

    always #5 clk = ~clk;

    assign cur = {rsp_id, rsp_y, rsp_co, rsp_ovf, rsp_zero};

    alb_scheduler #(.DATA_WIDTH(11), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_ci(r0_ci),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_ci(r1_ci),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .rsp_co(rsp_co), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );

    // Reference ALB from signed/unsigned integer arithmetic on the operand values
    function automatic rsp_t ref_model(input logic id, input logic [1:0] op,
                                       input logic [10:0] a, input logic [10:0] b, input logic ci);
        rsp_t r;
        int ua, ub, sa, sb, s, ss, c;
        ua = int'(a); ub = int'(b); c = ci ? 1 : 0;
        sa = a[10] ? ua - 2048 : ua;
        sb = b[10] ? ub - 2048 : ub;
        s = 0; ss = 0;
        r.id = id; r.co = 1'b0; r.ovf = 1'b0;
        case (op)
            2'b00: r.y = b | a;
            2'b10: r.y = ~b & a;
            2'b01: begin s = ub + ua + c;          ss = sb + sa + c;     end
            default: begin s = ub + (2047 - ua) + c; ss = sb - sa - 1 + c; end
        endcase
        if (op == 2'b01 || op == 2'b11) begin
            r.y   = s[10:0];
            r.co  = (s >= 2048);
            r.ovf = (ss > 1023) || (ss < -1024);
        end
        r.zero = (r.y == 11'd0);
        return r;
    endfunction

    // Monitor: pushes expectations on accepted requests, checks results on taken responses
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            resp_cnt = 0;
            hold = 1'b0;
        end else begin
            if (r0_ready || r1_ready) begin
                checks++;
                if (r0_ready && r1_ready) begin
                    errors++; $display("FAIL ready_mutex r0_ready=%b r1_ready=%b required at most one", r0_ready, r1_ready);
                end
            end
            if (hold) begin
                checks++;
                if (!rsp_valid || cur !== held) begin
                    errors++; $display("FAIL rsp_stable got %h valid=%b required %h", cur, rsp_valid, held);
                end
            end
            if (rsp_valid && !rsp_ready) begin
                checks++;
                if (r0_ready || r1_ready) begin
                    errors++; $display("FAIL bp_ready r0_ready=%b r1_ready=%b required 0", r0_ready, r1_ready);
                end
            end
            if (r0_valid && r0_ready) exp_q.push_back(ref_model(1'b0, r0_op, r0_a, r0_b, r0_ci));
            if (r1_valid && r1_ready) exp_q.push_back(ref_model(1'b1, r1_op, r1_a, r1_b, r1_ci));
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_unexpected got %h required no response", cur);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++; $display("FAIL sb_result got %h required %h", cur, e);
                    end
                end
                id_log.push_back(rsp_id);
                resp_cnt++;
            end
            hold = rsp_valid && !rsp_ready;
            held = cur;
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++; $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the handshake edge
    task automatic drive(input int rq, input logic [1:0] op, input logic [10:0] a,
                         input logic [10:0] b, input logic ci);
        bit got = 1'b0;
        if (rq == 0) begin r0_op = op; r0_a = a; r0_b = b; r0_ci = ci; r0_valid = 1'b1; end
        else         begin r1_op = op; r1_a = a; r1_b = b; r1_ci = ci; r1_valid = 1'b1; end
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            got = (rq == 0) ? r0_ready : r1_ready;
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL handshake_timeout r%0d ready=0 required 1", rq);
        end
        @(posedge clk); #1;
        if (rq == 0) r0_valid = 1'b0; else r1_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rsp_timeout rsp_valid=0 required 1");
        end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int k = 0; k < 300 && !idle; k++) begin
            @(negedge clk);
            idle = !busy && !rsp_valid;
        end
        checks++;
        if (!idle) begin
            errors++; $display("FAIL idle_timeout busy=%b rsp_valid=%b required 0", busy, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic directed(input string name, input int rq, input logic [1:0] op,
                            input logic [10:0] a, input logic [10:0] b, input logic ci,
                            input logic [10:0] ey, input logic eco, input logic eovf);
        bit   ok;
        rsp_t e;
        drive(rq, op, a, b, ci);
        wait_rsp(ok);
        e = {rq[0], ey, eco, eovf, (ey == 11'd0)};
        if (ok) begin
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL %s got %h required %h", name, cur, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_stream(input int rq, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            drive(rq, 2'($urandom_range(0, 3)), 11'($urandom), 11'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        reset = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = OP_ADD; r0_a = 11'h001; r0_b = 11'h001; r0_ci = 1'b0;
        r1_valid = 1'b0; r1_op = OP_OR;  r1_a = '0; r1_b = '0; r1_ci = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset_r0_ready", int'(r0_ready), 0);
        check_val("reset_rsp_valid", int'(rsp_valid), 0);
        check_val("reset_busy", int'(busy), 0);
        check_val("reset_op_count", int'(op_count), 0);
        @(posedge clk); #1;
        r0_valid = 1'b0; reset = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;

        directed("add_ovf",   0, OP_ADD,  11'h297, 11'h18E, 1'b0, 11'h425, 1'b0, 1'b1);
        directed("sub_borrow",0, OP_SUB,  11'h297, 11'h18E, 1'b1, 11'h6F7, 1'b0, 1'b0);
        directed("sub_noborr",1, OP_SUB,  11'h569, 11'h672, 1'b1, 11'h109, 1'b1, 1'b0);
        directed("or",        0, OP_OR,   11'h400, 11'h001, 1'b1, 11'h401, 1'b0, 1'b0);
        directed("andn",      1, OP_ANDN, 11'h7FF, 11'h555, 1'b0, 11'h2AA, 1'b0, 1'b0);
        directed("sub_zero",  1, OP_SUB,  11'h123, 11'h123, 1'b1, 11'h000, 1'b1, 1'b0);

        // Fairness from a clean reset
        reset = 1'b0; @(posedge clk); #1; reset = 1'b1; @(posedge clk); #1;
        id_log.delete();
        fork
            for (int i = 0; i < 4; i++) drive(0, OP_ADD, 11'($urandom), 11'($urandom), 1'b0);
            for (int i = 0; i < 4; i++) drive(1, OP_SUB, 11'($urandom), 11'($urandom), 1'b1);
        join
        wait_idle();
        check_val("fair_count", id_log.size(), 8);
        for (int i = 0; i < 8 && i < id_log.size(); i++)
            check_val($sformatf("fair_id%0d", i), int'(id_log[i]), i % 2);
        check_val("fair_op_count", int'(op_count), 8);

        // Back-pressure: result held, no grants while stalled
        rsp_ready = 1'b0;
        drive(0, OP_ADD, 11'h3FF, 11'h001, 1'b0);
        wait_rsp(ok);
        @(posedge clk); #1;
        r1_op = OP_OR; r1_a = 11'h0F0; r1_b = 11'h00F; r1_ci = 1'b0; r1_valid = 1'b1;
        repeat (5) @(negedge clk);
        check_val("bp_valid", int'(rsp_valid), 1);
        check_val("bp_r0_ready", int'(r0_ready), 0);
        check_val("bp_r1_ready", int'(r1_ready), 0);
        check_val("bp_y", int'(rsp_y), 'h400);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive(1, OP_OR, 11'h0F0, 11'h00F, 1'b0);
        wait_idle();

        // Reset while the accepted op sits in EXEC
        drive(1, OP_ADD, 11'h011, 11'h022, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check_val("rst_rsp_valid", int'(rsp_valid), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_op_count", int'(op_count), 0);
        @(posedge clk); #1;
        id_log.delete();
        fork
            drive(0, OP_OR, 11'h001, 11'h002, 1'b0);
            drive(1, OP_OR, 11'h004, 11'h008, 1'b0);
        join
        wait_idle();
        check_val("rst_first_grant", (id_log.size() > 0) ? int'(id_log[0]) : -1, 0);

        // Random concurrent traffic with random response back-pressure
        stop_rr = 1'b0;
        fork
            begin
                fork
                    rand_stream(0, 150);
                    rand_stream(1, 150);
                join
                stop_rr = 1'b1;
            end
            while (!stop_rr) begin
                @(posedge clk); #1;
                rsp_ready = ($urandom_range(0, 9) < 7);
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        check_val("drain_queue", exp_q.size(), 0);
        check_val("final_op_count", int'(op_count), resp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
